ball_motion_ctrl: RTL and testbench

Frame-rate sequencer that owns the ball position and size consumed by the colour mapper (BallX, BallY, Ball_size).
- Once per video frame, it takes the latest keyboard keycode and the wall-bounce rules, selects a velocity, advances the position and publishes it.
- Sits between the USB keycode register, the VGA controller's vertical-sync output and the colour mapper.

---
 rtl/ball_pkg.sv | 32 +++
 rtl/frame_tick_sync.sv | 22 ++
 rtl/ball_motion_ctrl.sv | 168 ++++++++++++++++
 tb/tb_ball_motion_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/ball_pkg.sv
// rtl/ball_pkg.sv - shared keycodes, FSM state and velocity type for ball motion
package ball_pkg;

    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_SPACE = 8'h2C;

    typedef enum logic [1:0] {
        IDLE,
        VEL,
        MOVE,
        DONE
    } state_t;

    typedef logic signed [10:0] vel_t;

    // Sums may dip below zero by up to STEP, so compare at signed width before narrowing.
    function automatic logic [9:0] clamp_coord(input vel_t pos, input vel_t lo, input vel_t hi);
        vel_t r;
        if (pos < lo) begin
            r = lo;
        end else if (pos > hi) begin
            r = hi;
        end else begin
            r = pos;
        end
        return r[9:0];
    endfunction

endpackage

// File: rtl/frame_tick_sync.sv
// rtl/frame_tick_sync.sv - 2-flop synchroniser plus rising-edge detector for a frame strobe
module frame_tick_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic tick_o
);

    // sync_q[0]/[1] are the synchroniser pair, sync_q[2] is the edge-detector history.
    logic [2:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], async_i};
        end
    end

    assign tick_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/ball_motion_ctrl.sv
// rtl/ball_motion_ctrl.sv - per-frame ball velocity/position sequencer; optional BALL_PAUSE_EN
module ball_motion_ctrl
    import ball_pkg::*;
#(
    parameter int X_MIN  = 0,
    parameter int X_MAX  = 639,
    parameter int Y_MIN  = 0,
    parameter int Y_MAX  = 479,
    parameter int STEP   = 1,
    parameter int SIZE   = 4,
    parameter int X_INIT = 320,
    parameter int Y_INIT = 240
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    output logic [9:0] BallX,
    output logic [9:0] BallY,
    output logic [9:0] Ball_size,
    output logic       frame_done
);

    localparam vel_t STEP_V = vel_t'(STEP);
    localparam vel_t X_LO   = vel_t'(X_MIN + SIZE);
    localparam vel_t X_HI   = vel_t'(X_MAX - SIZE);
    localparam vel_t Y_LO   = vel_t'(Y_MIN + SIZE);
    localparam vel_t Y_HI   = vel_t'(Y_MAX - SIZE);

    state_t     state_q;
    vel_t       x_vel_q, y_vel_q;
    vel_t       x_vel_d, y_vel_d;
    logic [9:0] ball_x_q, ball_y_q;
    logic [9:0] ball_x_d, ball_y_d;
    logic       frame_done_q;
    logic       tick;
    logic       move_en;
    logic       bottom_hit, top_hit, right_hit, left_hit;
    vel_t       sum_x, sum_y;

    frame_tick_sync u_tick (
        .clk    (Clk),
        .rst_n  (Reset_n),
        .async_i(frame_clk),
        .tick_o (tick)
    );

    assign bottom_hit = ({1'b0, ball_y_q} + 11'(SIZE)) >= 11'(Y_MAX);
    assign top_hit    = {1'b0, ball_y_q} <= 11'(Y_MIN + SIZE);
    assign right_hit  = ({1'b0, ball_x_q} + 11'(SIZE)) >= 11'(X_MAX);
    assign left_hit   = {1'b0, ball_x_q} <= 11'(X_MIN + SIZE);

    // Wall bounces outrank the keyboard; an idle or unknown key keeps the ball coasting.
    always_comb begin
        x_vel_d = x_vel_q;
        y_vel_d = y_vel_q;
        if (bottom_hit) begin
            x_vel_d = '0;
            y_vel_d = -STEP_V;
        end else if (top_hit) begin
            x_vel_d = '0;
            y_vel_d = STEP_V;
        end else if (right_hit) begin
            x_vel_d = -STEP_V;
            y_vel_d = '0;
        end else if (left_hit) begin
            x_vel_d = STEP_V;
            y_vel_d = '0;
        end else begin
            case (keycode)
                KEY_W: begin
                    x_vel_d = '0;
                    y_vel_d = -STEP_V;
                end
                KEY_S: begin
                    x_vel_d = '0;
                    y_vel_d = STEP_V;
                end
                KEY_A: begin
                    x_vel_d = -STEP_V;
                    y_vel_d = '0;
                end
                KEY_D: begin
                    x_vel_d = STEP_V;
                    y_vel_d = '0;
                end
                default: begin
                    x_vel_d = x_vel_q;
                    y_vel_d = y_vel_q;
                end
            endcase
        end
    end

    assign sum_x    = vel_t'({1'b0, ball_x_q}) + x_vel_q;
    assign sum_y    = vel_t'({1'b0, ball_y_q}) + y_vel_q;
    assign ball_x_d = clamp_coord(sum_x, X_LO, X_HI);
    assign ball_y_d = clamp_coord(sum_y, Y_LO, Y_HI);

`ifdef BALL_PAUSE_EN
    logic paused_q;
    logic space_prev_q;
    logic space_now;

    assign space_now = (keycode == KEY_SPACE);
    assign move_en   = ~paused_q;

    // Toggle only on the press edge as seen across successive frames, not while held.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            paused_q     <= 1'b0;
            space_prev_q <= 1'b0;
        end else if (state_q == VEL) begin
            paused_q     <= paused_q ^ (space_now & ~space_prev_q);
            space_prev_q <= space_now;
        end
    end
`else
    assign move_en = 1'b1;
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= IDLE;
            x_vel_q      <= '0;
            y_vel_q      <= '0;
            ball_x_q     <= 10'(X_INIT);
            ball_y_q     <= 10'(Y_INIT);
            frame_done_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    frame_done_q <= 1'b0;
                    if (tick) begin
                        state_q <= VEL;
                    end
                end
                VEL: begin
                    x_vel_q <= x_vel_d;
                    y_vel_q <= y_vel_d;
                    state_q <= MOVE;
                end
                MOVE: begin
                    if (move_en) begin
                        ball_x_q <= ball_x_d;
                        ball_y_q <= ball_y_d;
                    end
                    frame_done_q <= 1'b1;
                    state_q      <= DONE;
                end
                DONE: begin
                    frame_done_q <= 1'b0;
                    state_q      <= IDLE;
                end
                default: begin
                    frame_done_q <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign BallX      = ball_x_q;
    assign BallY      = ball_y_q;
    assign Ball_size  = 10'(SIZE);
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// tb/tb_ball_motion_ctrl.sv - directed self-checking bench for ball_motion_ctrl
module tb_ball_motion_ctrl;

    logic       Clk;
    logic       Reset_n;
    logic       frame_clk;
    logic [7:0] keycode;
    logic [9:0] BallX, BallY, Ball_size;
    logic       frame_done;

    int n_cmp = 0;
    int n_err = 0;
    int missed = 0;
    int max_x = 0;
    int max_y = 0;
    bit fd_seen;

    ball_motion_ctrl dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .frame_clk (frame_clk),
        .keycode   (keycode),
        .BallX     (BallX),
        .BallY     (BallY),
        .Ball_size (Ball_size),
        .frame_done(frame_done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset_n   = 1'b0;
        frame_clk = 1'b0;
        keycode   = 8'h00;
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
    endtask

    // One frame_clk pulse; counts frames whose frame_done never arrives within the budget.
    task automatic run_frame(input logic [7:0] key);
        bit seen;
        seen = 1'b0;
        @(negedge Clk);
        keycode   = key;
        frame_clk = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge Clk);
            if (frame_done) seen = 1'b1;
        end
        if (!seen) missed++;
        if (int'(BallX) > max_x) max_x = int'(BallX);
        if (int'(BallY) > max_y) max_y = int'(BallY);
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    task automatic run_frames(input logic [7:0] key, input int n);
        for (int i = 0; i < n; i++) run_frame(key);
    endtask

    initial begin
        Reset_n   = 1'b0;
        frame_clk = 1'b0;
        keycode   = 8'h00;
        repeat (3) @(negedge Clk);
        check_eq("rst_hold_x", BallX, 320);
        check_eq("rst_hold_fd", frame_done, 0);
        Reset_n = 1'b1;
        @(negedge Clk);
        check_eq("rst_x", BallX, 320);
        check_eq("rst_y", BallY, 240);
        check_eq("rst_size", Ball_size, 4);
        check_eq("rst_fd", frame_done, 0);
        run_frames(8'h00, 3);
        check_eq("idle_x", BallX, 320);
        check_eq("idle_y", BallY, 240);
        check_eq("idle_frames", missed, 0);

        // Exact latency: frame_clk rises before P1, tick in P2..P3, commit at P5.
        @(negedge Clk);
        keycode   = 8'h07;
        frame_clk = 1'b1;
        repeat (4) @(negedge Clk);
        check_eq("lat_pre_x", BallX, 320);
        check_eq("lat_pre_fd", frame_done, 0);
        @(negedge Clk);
        check_eq("lat_commit_x", BallX, 321);
        check_eq("lat_done_fd", frame_done, 1);
        @(negedge Clk);
        check_eq("lat_done_width", frame_done, 0);
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);

        do_reset();
        missed = 0;
        run_frame(8'h16);
        run_frames(8'h00, 4);
        check_eq("coast_y", BallY, 245);
        check_eq("coast_x", BallX, 320);

        max_x = 0;
        run_frames(8'h07, 315);
        check_eq("right_reach_x", BallX, 635);
        check_eq("right_max_x", max_x, 635);
        run_frame(8'h07);
        check_eq("right_bounce_x", BallX, 634);
        check_eq("right_bounce_y", BallY, 245);

        max_y = 0;
        run_frames(8'h16, 230);
        check_eq("bottom_reach_y", BallY, 475);
        check_eq("bottom_reach_x", BallX, 634);
        run_frame(8'h16);
        check_eq("bottom_bounce_y", BallY, 474);
        run_frame(8'h16);
        check_eq("bottom_return_y", BallY, 475);
        run_frame(8'h07);
        check_eq("prio_y", BallY, 474);
        check_eq("prio_x", BallX, 634);
        check_eq("bottom_max_y", max_y, 475);
        check_eq("long_run_frames", missed, 0);

        // Reset asserted while the FSM sits in MOVE.
        @(negedge Clk);
        keycode   = 8'h00;
        frame_clk = 1'b1;
        repeat (4) @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        check_eq("midrst_x", BallX, 320);
        check_eq("midrst_y", BallY, 240);
        check_eq("midrst_fd", frame_done, 0);
        frame_clk = 1'b0;
        fd_seen   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            if (i == 2) Reset_n = 1'b1;
            if (frame_done) fd_seen = 1'b1;
        end
        check_eq("midrst_no_pulse", fd_seen, 0);
        check_eq("midrst_after_x", BallX, 320);

        do_reset();
        missed = 0;
        run_frame(8'h07);
        check_eq("space_pre_x", BallX, 321);
`ifdef BALL_PAUSE_EN
        run_frame(8'h2C);
        check_eq("pause_press_x", BallX, 321);
        run_frames(8'h00, 3);
        check_eq("pause_hold_x", BallX, 321);
        check_eq("pause_hold_y", BallY, 240);
        run_frame(8'h2C);
        check_eq("unpause_x", BallX, 322);
        check_eq("pause_frames", missed, 0);
`else
        run_frame(8'h2C);
        check_eq("space_ignored_x", BallX, 322);
        run_frame(8'h00);
        check_eq("space_coast_x", BallX, 323);
        check_eq("space_frames", missed, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
